// File: rtl/md5_digest_serializer.sv
// Captures an MD5 digest and streams it out as ASCII hex characters over valid/ready.
// Optional macro MD5_SER_CRLF_EN appends CR (0x0D) and LF (0x0A) after the hex text.
module md5_digest_serializer #(
    parameter bit UPPER_HEX = 1'b0,
    parameter int NIBBLES   = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] digest,
    input  logic         valid,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         overrun
);

`ifdef MD5_SER_CRLF_EN
    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    localparam logic [5:0] LAST_IDX = 6'(NIBBLES - 1);

    state_t       state;
    // Holds the nibbles still to be sent; the one on screen already lives in out_data.
    logic [123:0] shreg;
    logic [5:0]   index;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return (UPPER_HEX ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
    endfunction

    // NOTE: every register here is written with <= so all of them update from the
    // same pre-edge values; mixing in = would make results depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= '0;
            index     <= '0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // A digest arriving while a transfer is in progress is dropped and flagged.
            overrun <= valid && (state != IDLE);

            case (state)
                IDLE: begin
                    if (valid) begin
                        shreg     <= digest[123:0];
                        index     <= '0;
                        out_data  <= hex_char(digest[127:124]);
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (out_ready) begin
                        shreg <= {shreg[119:0], 4'h0};
                        if (index == LAST_IDX) begin
`ifdef MD5_SER_CRLF_EN
                            out_data <= 8'h0D;
                            state    <= TERM;
`else
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
`endif
                        end else begin
                            index    <= index + 6'd1;
                            out_data <= hex_char(shreg[123:120]);
                        end
                    end
                end

`ifdef MD5_SER_CRLF_EN
                TERM: begin
                    if (out_ready) begin
                        if (out_data == 8'h0D) begin
                            out_data <= 8'h0A;
                        end else begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_digest_serializer.sv
// Directed bench for md5_digest_serializer: lower- and upper-case instances share stimulus.
// Expected streams are hand-written hex strings; CR/LF are appended when MD5_SER_CRLF_EN is set.
module tb_md5_digest_serializer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] digest = '0;
    logic         valid = 1'b0;
    logic         out_ready = 1'b1;

    logic [7:0] data_lo, data_up;
    logic       ov_lo, ov_up, busy_lo, busy_up, ovr_lo, ovr_up;

    logic       sel = 1'b0;
    logic [7:0] obs_data;
    logic       obs_valid, obs_busy, obs_overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    int         stab_err, ovr_cnt, n_cycles;
    bit         timed_out;
    logic [15:0] ready_pat = 16'b1011_0010_1100_0110;

    always #5 clk = ~clk;

    md5_digest_serializer #(.UPPER_HEX(1'b0), .NIBBLES(32)) dut_lo (
        .clk(clk), .rst_n(rst_n), .digest(digest), .valid(valid),
        .out_data(data_lo), .out_valid(ov_lo), .out_ready(out_ready),
        .busy(busy_lo), .overrun(ovr_lo)
    );

    md5_digest_serializer #(.UPPER_HEX(1'b1), .NIBBLES(32)) dut_up (
        .clk(clk), .rst_n(rst_n), .digest(digest), .valid(valid),
        .out_data(data_up), .out_valid(ov_up), .out_ready(out_ready),
        .busy(busy_up), .overrun(ovr_up)
    );

    assign obs_data    = sel ? data_up : data_lo;
    assign obs_valid   = sel ? ov_up   : ov_lo;
    assign obs_busy    = sel ? busy_up : busy_lo;
    assign obs_overrun = sel ? ovr_up  : ovr_lo;

    function automatic string sfx();
`ifdef MD5_SER_CRLF_EN
        return "\\r\\n";
`else
        return "";
`endif
    endfunction

    function automatic int exp_len();
`ifdef MD5_SER_CRLF_EN
        return 34;
`else
        return 32;
`endif
    endfunction

    // CR/LF are rendered as printable escapes so FAIL lines stay on one line.
    function automatic string render();
        string s = "";
        foreach (rx_q[i]) begin
            if (rx_q[i] == 8'h0D)      s = {s, "\\r"};
            else if (rx_q[i] == 8'h0A) s = {s, "\\n"};
            else                       s = {s, $sformatf("%c", rx_q[i])};
        end
        return s;
    endfunction

    // NOTE: inputs change 1 time unit after the rising edge with blocking assignments,
    // so the DUT never sees them race its own sampling edge.
    task automatic send_digest(input logic [127:0] d);
        digest = d;
        valid  = 1'b1;
        @(posedge clk); #1;
        valid  = 1'b0;
    endtask

    // Drains the current transfer, optionally pulsing valid when char inject_at is accepted.
    task automatic collect(input int ready_mode, input int inject_at, input int max_cycles);
        logic [7:0] prev_data = 8'h00;
        logic       prev_stall = 1'b0;
        bit         injected = 1'b0;
        int         cyc = 0;
        rx_q.delete();
        stab_err = 0;
        ovr_cnt  = 0;
        while (obs_busy === 1'b1 && cyc < max_cycles) begin
            if (prev_stall && (obs_valid !== 1'b1 || obs_data !== prev_data)) stab_err++;
            out_ready = (ready_mode == 0) ? 1'b1 : ready_pat[cyc % 16];
            if (!injected && inject_at >= 0 && rx_q.size() == inject_at
                && obs_valid === 1'b1 && out_ready) begin
                digest   = 128'h0;
                valid    = 1'b1;
                injected = 1'b1;
            end
            if (obs_valid === 1'b1 && out_ready) rx_q.push_back(obs_data);
            prev_stall = (obs_valid === 1'b1) && !out_ready;
            prev_data  = obs_data;
            @(posedge clk); #1;
            valid = 1'b0;
            cyc++;
            if (obs_overrun === 1'b1) ovr_cnt++;
        end
        n_cycles  = cyc;
        timed_out = (cyc >= max_cycles);
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", obs_valid); end
        total++;
        if (obs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", obs_busy); end
        total++;
        if (obs_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", obs_overrun); end
        total++;
        if (obs_data !== 8'h00) begin bad++; $display("FAIL reset_out_data: got %h want 00", obs_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: got valid=%b busy=%b want 0 0", obs_valid, obs_busy);
        end
    endtask

    task automatic test_stream_lower();
        string exp = {"0123456789abcdeffedcba9876543210", sfx()};
        sel = 1'b0;
        send_digest(128'h0123456789ABCDEFFEDCBA9876543210);
        total++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h30) begin
            bad++; $display("FAIL first_char_latency: got valid=%b data=%h want 1 30", obs_valid, obs_data);
        end
        collect(0, -1, 200);
        total++;
        if (timed_out) begin bad++; $display("FAIL lower_timeout: busy still high after %0d cycles", n_cycles); end
        total++;
        if (render() != exp) begin bad++; $display("FAIL lower_stream: got %s want %s", render(), exp); end
        total++;
        if (n_cycles != exp_len()) begin
            bad++; $display("FAIL lower_busy_fall: got %0d cycles want %0d", n_cycles, exp_len());
        end
        total++;
        if (obs_valid !== 1'b0 || ovr_cnt != 0) begin
            bad++; $display("FAIL lower_end_state: got valid=%b overruns=%0d want 0 0", obs_valid, ovr_cnt);
        end
    endtask

    task automatic test_stream_upper_stall();
        string exp = {"D41D8CD98F00B204E9800998ECF8427E", sfx()};
        sel = 1'b1;
        send_digest(128'hD41D8CD98F00B204E9800998ECF8427E);
        collect(1, -1, 400);
        total++;
        if (render() != exp) begin bad++; $display("FAIL upper_stream: got %s want %s", render(), exp); end
        total++;
        if (stab_err != 0) begin bad++; $display("FAIL stall_stability: got %0d violations want 0", stab_err); end
        total++;
        if (n_cycles <= exp_len() || timed_out) begin
            bad++; $display("FAIL stall_cycles: got %0d cycles want more than %0d", n_cycles, exp_len());
        end
        sel = 1'b0;
    endtask

    task automatic test_overrun_mid();
        string exp = {"0123456789abcdeffedcba9876543210", sfx()};
        sel = 1'b0;
        send_digest(128'h0123456789ABCDEFFEDCBA9876543210);
        collect(0, 10, 200);
        total++;
        if (ovr_cnt != 1) begin bad++; $display("FAIL overrun_mid_pulses: got %0d want 1", ovr_cnt); end
        total++;
        if (render() != exp) begin bad++; $display("FAIL overrun_mid_stream: got %s want %s", render(), exp); end
        total++;
        if (n_cycles != exp_len()) begin
            bad++; $display("FAIL overrun_mid_busy: got %0d cycles want %0d", n_cycles, exp_len());
        end
    endtask

    task automatic test_overrun_final();
        sel = 1'b0;
        send_digest(128'hFFFFFFFFFFFFFFFF0000000000000000);
        collect(0, exp_len() - 1, 200);
        total++;
        if (ovr_cnt != 1) begin bad++; $display("FAIL overrun_final_pulses: got %0d want 1", ovr_cnt); end
        @(posedge clk); #1;
        total++;
        if (obs_overrun !== 1'b0 || obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            bad++;
            $display("FAIL overrun_final_ignored: got ovr=%b busy=%b valid=%b want 0 0 0",
                     obs_overrun, obs_busy, obs_valid);
        end
    endtask

    task automatic test_async_reset();
        string exp = {"0f1e2d3c4b5a69788796a5b4c3d2e1f0", sfx()};
        sel = 1'b0;
        out_ready = 1'b1;
        send_digest(128'h0123456789ABCDEFFEDCBA9876543210);
        repeat (15) begin @(posedge clk); #1; end
        total++;
        if (obs_data !== 8'h66) begin bad++; $display("FAIL char15_before_reset: got %h want 66", obs_data); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (obs_valid !== 1'b0 || obs_busy !== 1'b0) begin
            bad++; $display("FAIL async_reset_drop: got valid=%b busy=%b want 0 0", obs_valid, obs_busy);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_digest(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
        total++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h30) begin
            bad++; $display("FAIL restart_first_char: got valid=%b data=%h want 1 30", obs_valid, obs_data);
        end
        collect(0, -1, 200);
        total++;
        if (render() != exp) begin bad++; $display("FAIL restart_stream: got %s want %s", render(), exp); end
    endtask

    task automatic test_all_ff();
        string exp = {"ffffffffffffffffffffffffffffffff", sfx()};
        sel = 1'b0;
        send_digest({128{1'b1}});
        collect(0, -1, 200);
        total++;
        if (render() != exp) begin bad++; $display("FAIL all_ff_stream: got %s want %s", render(), exp); end
        total++;
        if (rx_q.size() != exp_len() || n_cycles != exp_len()) begin
            bad++;
            $display("FAIL all_ff_length: got %0d chars in %0d cycles want %0d", rx_q.size(), n_cycles, exp_len());
        end
    endtask

    initial begin
        test_reset();
        test_stream_lower();
        test_stream_upper_stall();
        test_overrun_mid();
        test_overrun_final();
        test_async_reset();
        test_all_ff();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
